pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game control: state machine, pause timer, BCD score, ball count
module pong_game_ctrl #(
  parameter int LIVES     = 3,
  parameter int TIMER_LEN = 120,
  parameter int REFRESH_Y = 481
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] state,
  output logic [1:0] balls,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       timer_up
);

  localparam logic [1:0] S_NEWGAME = 2'b00;
  localparam logic [1:0] S_PLAY    = 2'b01;
  localparam logic [1:0] S_NEWBALL = 2'b10;
  localparam logic [1:0] S_OVER    = 2'b11;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [1:0] LIVES_PLAY = 2'(LIVES - 1);
  localparam logic [6:0] TIMER_INIT = 7'(TIMER_LEN);

  logic       ref_cond;
  logic       ref_cond_q;
  logic       ref_tick;
  logic [6:0] timer_q;
  logic       timer_start;
  logic       pressed;

  logic [1:0] state_q, state_next;
  logic [1:0] balls_q, balls_next;
  logic [3:0] dig1_q, dig1_next;
  logic [3:0] dig0_q, dig0_next;
  logic [3:0] dig1_inc, dig0_inc;

  assign ref_cond = (pixel_x == 10'd0) && (pixel_y == 10'(REFRESH_Y));
  assign ref_tick = ref_cond & ~ref_cond_q;
  assign pressed  = (btn != 2'b00);

  // Remember last cycle's refresh coordinate match so a held coordinate ticks only once
  always_ff @(posedge clk) begin
    if (rst) ref_cond_q <= 1'b0;
    else     ref_cond_q <= ref_cond;
  end

  // Pause timer: load wins over a same-cycle decrement, saturates at zero
  always_ff @(posedge clk) begin
    if (rst)                            timer_q <= 7'd0;
    else if (timer_start)               timer_q <= TIMER_INIT;
    else if (ref_tick && timer_q != '0) timer_q <= timer_q - 7'd1;
  end

  // State and game data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NEWGAME;
      balls_q <= LIVES_INIT;
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
    end else begin
      state_q <= state_next;
      balls_q <= balls_next;
      dig1_q  <= dig1_next;
      dig0_q  <= dig0_next;
    end
  end

  // BCD score plus one, 99 wraps to 00
  always_comb begin
    dig0_inc = dig0_q + 4'd1;
    dig1_inc = dig1_q;
    if (dig0_q == 4'd9) begin
      dig0_inc = 4'd0;
      dig1_inc = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
    end
  end

  // Next-state and data update; miss outranks hit, hit/miss ignored outside PLAY
  always_comb begin
    state_next  = state_q;
    balls_next  = balls_q;
    dig1_next   = dig1_q;
    dig0_next   = dig0_q;
    timer_start = 1'b0;
    case (state_q)
      S_NEWGAME: begin
        balls_next = LIVES_INIT;
        dig1_next  = 4'd0;
        dig0_next  = 4'd0;
        if (pressed) begin
          state_next = S_PLAY;
          balls_next = LIVES_PLAY;
        end
      end
      S_PLAY: begin
        if (miss) begin
          timer_start = 1'b1;
          if (balls_q == 2'd0) begin
            state_next = S_OVER;
          end else begin
            state_next = S_NEWBALL;
            balls_next = balls_q - 2'd1;
          end
        end else if (hit) begin
          dig1_next = dig1_inc;
          dig0_next = dig0_inc;
        end
      end
      S_NEWBALL: begin
        if (timer_q == '0 && pressed) state_next = S_PLAY;
      end
      S_OVER: begin
        // Enter NEWGAME already showing a fresh game so outputs never expose stale values
        if (timer_q == '0) begin
          state_next = S_NEWGAME;
          balls_next = LIVES_INIT;
          dig1_next  = 4'd0;
          dig0_next  = 4'd0;
        end
      end
      default: state_next = S_NEWGAME;
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    state     = state_q;
    balls     = balls_q;
    dig1      = dig1_q;
    dig0      = dig0_q;
    gra_still = (state_q != S_PLAY);
    timer_up  = (timer_q == '0);
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl against a behavioural game model
module tb_pong_game_ctrl;

  localparam int LIVES = 3;
  localparam int TL    = 120;
  localparam int RY    = 481;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [9:0] pixel_x = 10'd7;
  logic [9:0] pixel_y = 10'd100;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [1:0] state;
  logic [1:0] balls;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       timer_up;

  int checks = 0;
  int failures = 0;

  // game model: mode 0 new game, 1 play, 2 new ball, 3 over
  int m_mode, m_balls, m_score, m_timer;
  bit m_prev;

  pong_game_ctrl #(.LIVES(LIVES), .TIMER_LEN(TL), .REFRESH_Y(RY)) dut (
    .clk(clk), .rst(rst), .btn(btn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hit(hit), .miss(miss), .gra_still(gra_still), .state(state), .balls(balls),
    .dig1(dig1), .dig0(dig0), .timer_up(timer_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit cond, tk, pressed, was_zero, start;
    if (rst) begin
      m_mode = 0; m_balls = LIVES; m_score = 0; m_timer = 0; m_prev = 0;
      return;
    end
    cond     = (pixel_x == 0) && (pixel_y == RY);
    tk       = cond && !m_prev;
    m_prev   = cond;
    pressed  = (btn != 0);
    was_zero = (m_timer == 0);
    start    = 0;
    case (m_mode)
      0: begin
        m_balls = LIVES; m_score = 0;
        if (pressed) begin m_mode = 1; m_balls = LIVES - 1; end
      end
      1: begin
        if (miss) begin
          start = 1;
          if (m_balls == 0) m_mode = 3;
          else begin m_mode = 2; m_balls = m_balls - 1; end
        end else if (hit) m_score = (m_score + 1) % 100;
      end
      2: if (was_zero && pressed) m_mode = 1;
      default: if (was_zero) begin m_mode = 0; m_balls = LIVES; m_score = 0; end
    endcase
    if (start) m_timer = TL;
    else if (tk && m_timer > 0) m_timer = m_timer - 1;
  endtask

  task automatic check_outputs();
    check("state", int'(state), m_mode);
    check("balls", int'(balls), m_balls);
    check("dig1", int'(dig1), m_score / 10);
    check("dig0", int'(dig0), m_score % 10);
    check("gra_still", int'(gra_still), (m_mode != 1) ? 1 : 0);
    check("timer_up", int'(timer_up), (m_timer == 0) ? 1 : 0);
    check("timer", int'(dut.timer_q), m_timer);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_cond(input bit on);
    pixel_x = on ? 10'd0 : 10'(($urandom_range(1, 639)));
    pixel_y = on ? 10'(RY) : 10'(($urandom_range(0, 479)));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      set_cond(1); tick();
      set_cond(0); tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] b);
    btn = b; tick(); btn = 2'b00;
  endtask

  task automatic pulse_miss();
    miss = 1'b1; tick(); miss = 1'b0;
  endtask

  initial begin
    // reset state
    rst = 1'b1; tick(); tick();
    check("rst_state", int'(state), 0);
    check("rst_balls", int'(balls), 3);
    check("rst_timer_up", int'(timer_up), 1);
    check("rst_gra_still", int'(gra_still), 1);
    rst = 1'b0; tick();

    // start a game
    press(2'b01);
    check("start_state", int'(state), 1);
    check("start_balls", int'(balls), 2);
    check("start_gra_still", int'(gra_still), 0);
    check("start_score", {24'd0, dig1, dig0}, 0);

    // twelve hits, then wrap after one hundred
    for (int i = 0; i < 12; i++) begin hit = 1'b1; tick(); hit = 1'b0; tick(); end
    check("score12", {24'd0, dig1, dig0}, 32'h12);
    for (int i = 0; i < 88; i++) begin hit = 1'b1; tick(); hit = 1'b0; end
    check("score_wrap", {24'd0, dig1, dig0}, 0);
    hit = 1'b1; tick(); hit = 1'b0;
    check("score_after_wrap", int'(dig0), 1);

    // rst pulse between edges has no effect
    rst = 1'b1; #3; rst = 1'b0; tick();
    check("midcycle_rst_state", int'(state), 1);

    // hit and miss together: miss wins
    hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
    check("hm_state", int'(state), 2);
    check("hm_balls", int'(balls), 1);
    check("hm_dig0", int'(dig0), 1);
    check("hm_timer", int'(dut.timer_q), 120);

    // held refresh coordinate decrements once
    set_cond(1); repeat (4) tick();
    check("hold_timer", int'(dut.timer_q), 119);
    set_cond(0); tick();
    hit = 1'b1; tick(); hit = 1'b0;
    check("hit_ignored", int'(dig0), 1);

    // press while timer nonzero is ignored
    frames(114);
    check("timer5", int'(dut.timer_q), 5);
    press(2'b01);
    check("early_press_state", int'(state), 2);
    frames(5);
    check("timer_done", int'(timer_up), 1);
    press(2'b10);
    check("resume_state", int'(state), 1);

    // play down to game over and back to new game
    do_reset();
    press(2'b11);
    pulse_miss(); frames(120); press(2'b01);
    pulse_miss(); frames(120); press(2'b01);
    check("last_ball", int'(balls), 0);
    hit = 1'b1; tick(); hit = 1'b0;
    pulse_miss();
    check("over_state", int'(state), 3);
    check("over_balls", int'(balls), 0);
    btn = 2'b01; frames(120); btn = 2'b00;
    check("over_to_new_state", int'(state), 0);
    tick();
    check("newgame_balls", int'(balls), 3);
    check("newgame_score", {24'd0, dig1, dig0}, 0);

    // reset during pause
    press(2'b01);
    pulse_miss();
    frames(60);
    check("pause_timer60", int'(dut.timer_q), 60);
    rst = 1'b1; miss = 1'b1; btn = 2'b01; tick(); rst = 1'b0; miss = 1'b0; btn = 2'b00;
    check("pause_rst_state", int'(state), 0);
    check("pause_rst_balls", int'(balls), 3);
    check("pause_rst_timer_up", int'(timer_up), 1);
    check("pause_rst_score", {24'd0, dig1, dig0}, 0);

    // randomized play against the model
    for (int i = 0; i < 6000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      btn  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hit  = ($urandom_range(0, 2) == 0);
      miss = ($urandom_range(0, 59) == 0);
      set_cond($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
